// File: rtl/l_buffer_preload_sequencer_if.sv
// Source-stream and latency-buffer load bus of the preload sequencer.
//  master : preprocess source + buffer side (drives source streams, observes strobes)
//  slave  : sequencer side (accepts source streams, drives buffer load strobes)
//  src_node/src_node_valid/src_node_ready : clause stream (CLA_LENGTH literal fields of PTR_W)
//  src_ptr/src_ptr_valid/src_ptr_ready    : pointer stream
//  lb_*                                   : per-cycle load strobes and data toward the buffer
interface l_buffer_preload_sequencer_if #(
  parameter int unsigned PTR_W      = 8,
  parameter int unsigned CLA_LENGTH = 3
);
  localparam int unsigned NODE_W = CLA_LENGTH * PTR_W;

  logic [NODE_W-1:0] src_node;
  logic              src_node_valid;
  logic              src_node_ready;
  logic [PTR_W-1:0]  src_ptr;
  logic              src_ptr_valid;
  logic              src_ptr_ready;
  logic [NODE_W-1:0] lb_clause;
  logic              lb_load_clause;
  logic              lb_change_engine;
  logic [PTR_W-1:0]  lb_ptr;
  logic              lb_load_ptr;

  modport master (
    output src_node, src_node_valid, src_ptr, src_ptr_valid,
    input  src_node_ready, src_ptr_ready,
    input  lb_clause, lb_load_clause, lb_change_engine, lb_ptr, lb_load_ptr
  );

  modport slave (
    input  src_node, src_node_valid, src_ptr, src_ptr_valid,
    output src_node_ready, src_ptr_ready,
    output lb_clause, lb_load_clause, lb_change_engine, lb_ptr, lb_load_ptr
  );
endinterface

// File: rtl/l_buffer_preload_sequencer.sv
// Transmit side of the latency-buffer preload protocol: drains a clause stream
// (engine by engine, with a change-engine pulse) and then a pointer stream,
// producing one-cycle load strobes one cycle after each accepted beat.
//  clock, reset   : rising-edge clock, asynchronous active-low reset
//  start, abort   : begin preload (IDLE only) / synchronous return to IDLE
//  cla_per_engine : clauses per engine, captured when start is accepted
//  bus            : source streams in, buffer load strobes out
//  engine_idx     : engine being loaded (clause or pointer phase)
//  busy, done     : not idle / one-cycle completion pulse
module l_buffer_preload_sequencer #(
  parameter int unsigned NUM_ENGINE  = 2,
  parameter int unsigned CLA_LENGTH  = 3,
  parameter int unsigned LIT_IDX_MAX = 4,
  parameter int unsigned CLQ_DEPTH   = 64,
  parameter int unsigned PTR_W       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(CLQ_DEPTH):0]    cla_per_engine,
  l_buffer_preload_sequencer_if.slave   bus,
  output logic [$clog2(NUM_ENGINE):0]   engine_idx,
  output logic                          busy,
  output logic                          done
);
  localparam int unsigned CNT_W        = $clog2(CLQ_DEPTH) + 1;
  localparam int unsigned ENG_W        = $clog2(NUM_ENGINE) + 1;
  localparam int unsigned PTRS_PER_ENG = 2 * LIT_IDX_MAX;
  localparam int unsigned PTR_TOTAL    = NUM_ENGINE * PTRS_PER_ENG;
  localparam int unsigned PCNT_W       = $clog2(PTR_TOTAL) + 1;
  localparam int unsigned NODE_W       = CLA_LENGTH * PTR_W;

  typedef enum logic [2:0] {S_IDLE, S_CLA, S_GAP, S_PTR, S_FIN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cla_cfg, cla_cnt;
  logic [ENG_W-1:0]    eng_cnt;
  logic [PCNT_W-1:0]   ptr_cnt;
  logic [NODE_W-1:0]   clause_q;
  logic [PTR_W-1:0]    ptr_q;
  logic                load_clause_q, change_engine_q, load_ptr_q;
  logic                node_hs_c, ptr_hs_c, last_cla_c, last_ptr_c, eng_wrap_c;

  // Handshakes decoded from state directly rather than from the ready outputs.
  assign node_hs_c  = bus.src_node_valid && (state == S_CLA);
  assign ptr_hs_c   = bus.src_ptr_valid && (state == S_PTR);
  assign eng_wrap_c = (cla_cnt == cla_cfg - CNT_W'(1));
  assign last_cla_c = node_hs_c && eng_wrap_c && (eng_cnt == ENG_W'(NUM_ENGINE - 1));
  assign last_ptr_c = ptr_hs_c && (ptr_cnt == PCNT_W'(PTR_TOTAL - 1));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (cla_per_engine != '0) ? S_CLA : S_GAP;
      S_CLA:  if (last_cla_c) state_nxt = S_GAP;
      S_GAP:  state_nxt = S_PTR;
      S_PTR:  if (last_ptr_c) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    bus.src_node_ready = 1'b0;
    bus.src_ptr_ready  = 1'b0;
    busy               = (state != S_IDLE);
    done               = (state == S_FIN);
    engine_idx         = '0;
    case (state)
      S_CLA: begin
        bus.src_node_ready = 1'b1;
        engine_idx         = eng_cnt;
      end
      S_PTR: begin
        bus.src_ptr_ready = 1'b1;
        engine_idx        = ENG_W'(ptr_cnt / PCNT_W'(PTRS_PER_ENG));
      end
      default: ;
    endcase
  end

  // Counters, captured configuration and one-cycle-delayed load strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cla_cfg         <= '0;
      cla_cnt         <= '0;
      eng_cnt         <= '0;
      ptr_cnt         <= '0;
      clause_q        <= '0;
      ptr_q           <= '0;
      load_clause_q   <= 1'b0;
      change_engine_q <= 1'b0;
      load_ptr_q      <= 1'b0;
    end else if (abort) begin
      cla_cnt         <= '0;
      eng_cnt         <= '0;
      ptr_cnt         <= '0;
      load_clause_q   <= 1'b0;
      change_engine_q <= 1'b0;
      load_ptr_q      <= 1'b0;
    end else begin
      load_clause_q   <= node_hs_c;
      change_engine_q <= node_hs_c && (cla_cnt == '0) && (eng_cnt != '0);
      load_ptr_q      <= ptr_hs_c;
      if (node_hs_c) clause_q <= bus.src_node;
      if (ptr_hs_c)  ptr_q    <= bus.src_ptr;
      if ((state == S_IDLE) && start) begin
        cla_cfg <= cla_per_engine;
        cla_cnt <= '0;
        eng_cnt <= '0;
        ptr_cnt <= '0;
      end
      if (node_hs_c) begin
        if (eng_wrap_c) begin
          cla_cnt <= '0;
          eng_cnt <= eng_cnt + ENG_W'(1);
        end else begin
          cla_cnt <= cla_cnt + CNT_W'(1);
        end
      end
      if (ptr_hs_c) ptr_cnt <= ptr_cnt + PCNT_W'(1);
    end
  end

  assign bus.lb_clause        = clause_q;
  assign bus.lb_load_clause   = load_clause_q;
  assign bus.lb_change_engine = change_engine_q;
  assign bus.lb_ptr           = ptr_q;
  assign bus.lb_load_ptr      = load_ptr_q;
endmodule

// File: tb/tb_l_buffer_preload_sequencer.sv
// Directed bench for l_buffer_preload_sequencer: drives clause/pointer streams,
// logs every load strobe and done pulse, and compares against hand-computed lists.
module tb_l_buffer_preload_sequencer;
  localparam logic [23:0] NODE_BASE = 24'hA00000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] cla_per_engine = '0;
  logic [1:0] engine_idx;
  logic       busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc, done_cyc, last_ptr_cyc;
  int done_cnt, both_cnt, ce_orphan;
  logic [23:0] clq[$];
  logic        ceq[$];
  logic [7:0]  pq[$];

  l_buffer_preload_sequencer_if #(.PTR_W(8), .CLA_LENGTH(3)) sif ();

  l_buffer_preload_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cla_per_engine (cla_per_engine),
    .bus            (sif),
    .engine_idx     (engine_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe and done logger.
  always @(negedge clock) begin
    if (sif.lb_load_clause) begin
      clq.push_back(sif.lb_clause);
      ceq.push_back(sif.lb_change_engine);
    end
    if (sif.lb_change_engine && !sif.lb_load_clause) ce_orphan++;
    if (sif.lb_load_ptr) begin
      pq.push_back(sif.lb_ptr);
      last_ptr_cyc = cyc;
    end
    if (sif.lb_load_clause && sif.lb_load_ptr) both_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    clq.delete();
    ceq.delete();
    pq.delete();
    done_cnt  = 0;
    both_cnt  = 0;
    ce_orphan = 0;
    done_cyc  = -1;
  endtask

  task automatic start_run(input int cla);
    start          = 1'b1;
    cla_per_engine = 7'(cla);
    step();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Streams nodes [first,last); optional valid toggling and a start pulse at pulse_idx.
  task automatic feed_nodes(input int first, input int last, input bit toggle, input int pulse_idx);
    int idx   = first;
    int guard = 0;
    bit ph    = 1'b0;
    bit hs;
    while (idx < last && guard < 200) begin
      sif.src_node       = NODE_BASE + 24'(idx);
      sif.src_node_valid = toggle ? ~ph : 1'b1;
      ph                 = ~ph;
      start              = (idx == pulse_idx);
      if (idx == pulse_idx) cla_per_engine = '0;
      hs = sif.src_node_valid && sif.src_node_ready;
      step();
      guard++;
      if (hs) idx++;
    end
    sif.src_node_valid = 1'b0;
    start              = 1'b0;
    check("node_feed_budget", 32'(guard < 200), 1);
  endtask

  // Streams pointers [first,last) with value index+1.
  task automatic feed_ptrs(input int first, input int last);
    int idx   = first;
    int guard = 0;
    bit hs;
    while (idx < last && guard < 200) begin
      sif.src_ptr       = 8'(idx + 1);
      sif.src_ptr_valid = 1'b1;
      hs = sif.src_ptr_valid && sif.src_ptr_ready;
      step();
      guard++;
      if (hs) begin
        idx++;
        if (idx == 8) check("ptr_engine_idx", 32'(engine_idx), 1);
      end
    end
    sif.src_ptr_valid = 1'b0;
    check("ptr_feed_budget", 32'(guard < 200), 1);
  endtask

  task automatic verify(input string t, input int n_cla, input int ce_at, input int n_ptr, input int n_done);
    check({t, "_clause_cnt"}, 32'(clq.size()), 32'(n_cla));
    for (int i = 0; i < n_cla && i < clq.size(); i++) begin
      check({t, "_clause_val"}, 32'(clq[i]), 32'(NODE_BASE + 24'(i)));
      check({t, "_change_eng"}, 32'(ceq[i]), 32'(i == ce_at));
    end
    check({t, "_ptr_cnt"}, 32'(pq.size()), 32'(n_ptr));
    for (int i = 0; i < n_ptr && i < pq.size(); i++)
      check({t, "_ptr_val"}, 32'(pq[i]), 32'(i + 1));
    check({t, "_done_cnt"}, 32'(done_cnt), 32'(n_done));
    check({t, "_both_strobes"}, 32'(both_cnt), 0);
    check({t, "_orphan_change"}, 32'(ce_orphan), 0);
  endtask

  task automatic run_t1(input string t, input int pulse_idx);
    clear_log();
    start_run(3);
    feed_nodes(0, 3, 1'b0, pulse_idx);
    check({t, "_cla_engine_idx"}, 32'(engine_idx), 1);
    feed_nodes(3, 6, 1'b0, -1);
    feed_ptrs(0, 16);
    repeat (3) step();
    verify(t, 6, 3, 16, 1);
    check({t, "_done_latency"}, 32'(done_cyc - start_cyc), 23);
    check({t, "_done_with_last_ptr"}, 32'(done_cyc), 32'(last_ptr_cyc));
    check({t, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    sif.src_node       = '0;
    sif.src_node_valid = 1'b0;
    sif.src_ptr        = '0;
    sif.src_ptr_valid  = 1'b0;
    clear_log();

    // Reset state.
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_node_ready", 32'(sif.src_node_ready), 0);
    check("rst_load_clause", 32'(sif.lb_load_clause), 0);
    check("rst_engine_idx", 32'(engine_idx), 0);
    #20 reset = 1'b1;
    step();

    // Source valid while idle is not consumed; start & abort together stays idle.
    sif.src_node_valid = 1'b1;
    sif.src_ptr_valid  = 1'b1;
    repeat (3) step();
    sif.src_node_valid = 1'b0;
    sif.src_ptr_valid  = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    cla_per_engine = 7'd3;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    step();
    check("idle_no_clause", 32'(clq.size()), 0);
    check("idle_no_ptr", 32'(pq.size()), 0);

    // T1 back-to-back.
    run_t1("t1", -1);

    // T2 clause valid toggling.
    clear_log();
    start_run(3);
    feed_nodes(0, 6, 1'b1, -1);
    feed_ptrs(0, 16);
    repeat (3) step();
    verify("t2", 6, 3, 16, 1);

    // T3 zero clauses per engine.
    clear_log();
    start_run(0);
    feed_ptrs(0, 16);
    repeat (3) step();
    verify("t3", 0, -1, 16, 1);
    check("t3_done_latency", 32'(done_cyc - start_cyc), 17);

    // T4 abort after the fourth clause, then a fresh full run.
    clear_log();
    start_run(3);
    feed_nodes(0, 4, 1'b0, -1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy_after_abort", 32'(busy), 0);
    check("t4_strobe_after_abort", 32'(sif.lb_load_clause), 0);
    repeat (4) step();
    verify("t4", 4, 3, 0, 0);
    run_t1("t4rerun", -1);

    // T5 asynchronous reset in the pointer phase.
    clear_log();
    start_run(3);
    feed_nodes(0, 6, 1'b0, -1);
    feed_ptrs(0, 5);
    check("t5_strobe_before_rst", 32'(sif.lb_load_ptr), 1);
    reset = 1'b0;
    #1;
    check("t5_load_ptr", 32'(sif.lb_load_ptr), 0);
    check("t5_lb_ptr", 32'(sif.lb_ptr), 0);
    check("t5_lb_clause", 32'(sif.lb_clause), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_ptr_ready", 32'(sif.src_ptr_ready), 0);
    #2 reset = 1'b1;
    step();
    check("t5_idle_after_release", 32'(busy), 0);
    check("t5_no_done", 32'(done_cnt), 0);

    // T6 start pulse during the clause phase is ignored.
    run_t1("t6", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
